usb_fifo_pkt: RTL and testbench

Synchronous bit-addressed FIFO with independent write and read widths, and packet-level commit/discard on both sides. The writer drops a whole received packet on CRC or PID error. The reader rewinds to the packet start to retransmit when no ACK arrives. It sits between the bit-serial transceiver logic and the endpoint byte interface. It generalises the plain width-converting FIFO with speculative pointers, occupancy outputs and an overflow flag.

---
 rtl/usb_fifo_pkt.sv | 92 +++++++++
 tb/tb_usb_fifo_pkt.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/usb_fifo_pkt.sv
// usb_fifo_pkt: bit-addressed packet FIFO with independent write/read word
// widths and speculative pointers on both sides.
//   Write side: wr_en/wr_data store words at the speculative wr_ptr.
//               wr_commit publishes them to the reader.
//               wr_drop rewinds wr_ptr to the committed wr_base.
//   Read side:  rd_data shows the word at the speculative rd_ptr.
//               rd_en advances rd_ptr. rd_commit frees the space read so far.
//               rd_rewind rewinds rd_ptr to the committed rd_base.
//   Status:     fifo_full, fifo_empty, wr_free, rd_avail are combinational
//               from the pointers. wr_ovf is a registered pulse raised when a
//               write hits a full FIFO.
module usb_fifo_pkt #(
    parameter int ADDR_WIDTH  = 5,
    parameter int WDATA_WIDTH = 3,
    parameter int RDATA_WIDTH = 0
) (
    input  logic                          clk,
    input  logic                          rst1_sync,
    input  logic                          wr_en,
    input  logic [(1<<WDATA_WIDTH)-1:0]   wr_data,
    input  logic                          wr_commit,
    input  logic                          wr_drop,
    input  logic                          rd_en,
    output logic [(1<<RDATA_WIDTH)-1:0]   rd_data,
    input  logic                          rd_commit,
    input  logic                          rd_rewind,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [ADDR_WIDTH:0]           wr_free,
    output logic [ADDR_WIDTH:0]           rd_avail,
    output logic                          wr_ovf
);
    localparam int FIFO_LENGTH = 1 << ADDR_WIDTH;
    localparam int WW = 1 << WDATA_WIDTH;
    localparam int RW = 1 << RDATA_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;

    logic [FIFO_LENGTH-1:0] mem;
    logic [PW-1:0] wr_ptr, wr_base, rd_ptr, rd_base;
    logic [PW-1:0] wr_ptr_next, rd_ptr_next;
    logic          wr_acc, rd_acc;

    // Pointers carry one extra lap bit, so modulo subtraction tells a full
    // FIFO (equal low bits, different lap) apart from an empty one.
    // Each side judges space against the other side's committed pointer.
    assign wr_free    = PW'(FIFO_LENGTH) - (wr_ptr - rd_base);
    assign rd_avail   = wr_base - rd_ptr;
    assign fifo_full  = wr_free < PW'(WW);
    assign fifo_empty = rd_avail < PW'(RW);

    // Show-ahead read. Read pointers stay RW-aligned, so the shifted word
    // never straddles the top of the memory.
    assign rd_data = RW'(mem >> rd_ptr[ADDR_WIDTH-1:0]);

    assign wr_acc      = wr_en & ~fifo_full & ~wr_drop;
    assign rd_acc      = rd_en & ~fifo_empty & ~rd_rewind;
    assign wr_ptr_next = wr_ptr + (wr_acc ? PW'(WW) : PW'(0));
    assign rd_ptr_next = rd_ptr + (rd_acc ? PW'(RW) : PW'(0));

    always_ff @(posedge clk) begin
        if (rst1_sync) begin
            mem     <= '0;
            wr_ptr  <= '0;
            wr_base <= '0;
            rd_ptr  <= '0;
            rd_base <= '0;
            wr_ovf  <= 1'b0;
        end else begin
            // A drop discards the whole uncommitted packet. It also discards
            // any write or commit issued in the same cycle.
            if (wr_drop) begin
                wr_ptr <= wr_base;
            end else begin
                if (wr_acc)
                    mem[wr_ptr[ADDR_WIDTH-1:0] +: WW] <= wr_data;
                wr_ptr <= wr_ptr_next;
                if (wr_commit)
                    wr_base <= wr_ptr_next;
            end

            if (rd_rewind) begin
                rd_ptr <= rd_base;
            end else begin
                rd_ptr <= rd_ptr_next;
                if (rd_commit)
                    rd_base <= rd_ptr_next;
            end

            wr_ovf <= wr_en & fifo_full;
        end
    end
endmodule

// File: tb/tb_usb_fifo_pkt.sv
// Directed bench for usb_fifo_pkt with default parameters
// (32-bit store, 8-bit write words, 1-bit read words).
module tb_usb_fifo_pkt;
    logic       clk = 1'b0;
    logic       rst1_sync;
    logic       wr_en, wr_commit, wr_drop;
    logic [7:0] wr_data;
    logic       rd_en, rd_commit, rd_rewind;
    logic [0:0] rd_data;
    logic       fifo_full, fifo_empty, wr_ovf;
    logic [5:0] wr_free, rd_avail;

    int total = 0;
    int bad   = 0;

    usb_fifo_pkt dut (
        .clk        (clk),
        .rst1_sync  (rst1_sync),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .wr_drop    (wr_drop),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_commit  (rd_commit),
        .rd_rewind  (rd_rewind),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .wr_free    (wr_free),
        .rd_avail   (rd_avail),
        .wr_ovf     (wr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_commit = 0; wr_drop = 0; wr_data = '0;
        rd_en = 0; rd_commit = 0; rd_rewind = 0;
    endtask

    task automatic wr(input logic [7:0] d, input bit commit);
        wr_en = 1; wr_data = d; wr_commit = commit;
        tick();
        idle();
    endtask

    // Read n bits LSB-first and compare the assembled word.
    // The last read optionally commits.
    task automatic rd_word(input string tag, input int n, input int exp, input bit commit);
        int got;
        got = 0;
        for (int i = 0; i < n; i++) begin
            got = got | (int'(rd_data) << i);
            rd_en = 1;
            rd_commit = commit && (i == n - 1);
            tick();
            idle();
        end
        chk(tag, got, exp);
    endtask

    initial begin
        logic [7:0] b;
        idle();
        rst1_sync = 1;
        tick();
        rst1_sync = 0;
        chk("rst_free", int'(wr_free), 32);
        chk("rst_avail", int'(rd_avail), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_full", int'(fifo_full), 0);
        chk("rst_ovf", int'(wr_ovf), 0);
        chk("rst_rdata", int'(rd_data), 0);

        // Two bytes, committed on the second.
        wr(8'hA5, 0);
        chk("spec_empty", int'(fifo_empty), 1);
        wr(8'h3C, 1);
        chk("t1_avail", int'(rd_avail), 16);
        rd_word("t1_bits", 16, 'h3CA5, 1);
        chk("t1_empty", int'(fifo_empty), 1);

        // Drop an uncommitted packet.
        wr(8'h11, 0);
        wr(8'h22, 0);
        chk("t2_spec_free", int'(wr_free), 16);
        wr_drop = 1; tick(); idle();
        chk("t2_empty", int'(fifo_empty), 1);
        chk("t2_free", int'(wr_free), 32);
        wr(8'h77, 1);
        rd_word("t2_byte", 8, 'h77, 1);

        // Rewind the reader mid-packet.
        wr(8'hF0, 1);
        rd_word("t3_part", 5, 'h10, 0);
        rd_rewind = 1; tick(); idle();
        chk("t3_rdata", int'(rd_data), 0);
        chk("t3_avail", int'(rd_avail), 8);
        rd_word("t3_byte", 8, 'hF0, 1);
        chk("t3_free", int'(wr_free), 32);

        // Fill completely, then overflow.
        wr(8'h01, 0); wr(8'h02, 0); wr(8'h04, 0); wr(8'h08, 1);
        chk("t4_full", int'(fifo_full), 1);
        chk("t4_free0", int'(wr_free), 0);
        wr(8'hFF, 1);
        chk("t4_ovf", int'(wr_ovf), 1);
        tick();
        chk("t4_ovf_clr", int'(wr_ovf), 0);
        chk("t4_avail", int'(rd_avail), 32);
        rd_word("t4_b0", 8, 'h01, 1);
        chk("t4_unfull", int'(fifo_full), 0);
        chk("t4_free8", int'(wr_free), 8);
        rd_word("t4_b1", 8, 'h02, 0);
        rd_word("t4_b2", 8, 'h04, 0);
        rd_word("t4_b3", 8, 'h08, 1);
        chk("t4_empty", int'(fifo_empty), 1);

        // Ten 3-byte packets; the pointers wrap several laps.
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 3; k++) begin
                b = 8'((p * 3 + k) * 37 + 5);
                chk("t5_nofull", int'(fifo_full), 0);
                wr(b, k == 2);
            end
            for (int k = 0; k < 3; k++) begin
                b = 8'((p * 3 + k) * 37 + 5);
                rd_word("t5_byte", 8, int'(b), k == 2);
            end
            chk("t5_free", int'(wr_free), 32);
        end

        // Reset while full and mid-packet, with every strobe high.
        wr(8'h5A, 0); wr(8'hC3, 0); wr(8'h99, 0); wr(8'h66, 1);
        chk("t6_full", int'(fifo_full), 1);
        rst1_sync = 1;
        wr_en = 1; wr_data = 8'hFF; wr_commit = 1; rd_en = 1; rd_commit = 1;
        tick();
        rst1_sync = 0;
        idle();
        chk("t6_free", int'(wr_free), 32);
        chk("t6_avail", int'(rd_avail), 0);
        chk("t6_empty", int'(fifo_empty), 1);
        chk("t6_ovf", int'(wr_ovf), 0);
        chk("t6_rdata", int'(rd_data), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
